// File: rtl/cv32e40s_hardening_alert_ctrl.sv
// Hardening checker sequencer: arms the checkers after enable, then aggregates
// their major/minor flags into sticky alerts with minor-event escalation.
module cv32e40s_hardening_alert_ctrl #(
  parameter int NUM_SRC      = 4,
  parameter int ARM_DELAY    = 2,
  parameter int MINOR_CNT_W  = 4,
  parameter int MINOR_THRESH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hardening_en_i,
  input  logic                   debug_mode_i,
  input  logic [NUM_SRC-1:0]     src_err_i,
  input  logic [NUM_SRC-1:0]     src_minor_i,
  input  logic [NUM_SRC-1:0]     src_mask_i,
  output logic                   check_en_o,
  output logic                   alert_major_o,
  output logic                   alert_minor_o,
  output logic [NUM_SRC:0]       err_src_o,
  output logic [MINOR_CNT_W-1:0] minor_cnt_o
);

  localparam int AW = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
  localparam logic [AW-1:0] ARM_INIT = AW'((ARM_DELAY > 0) ? ARM_DELAY - 1 : 0);
  localparam logic [MINOR_CNT_W-1:0] CNT_MAX = {MINOR_CNT_W{1'b1}};
  localparam logic [MINOR_CNT_W-1:0] THRESH  = MINOR_CNT_W'(MINOR_THRESH);

  typedef enum logic [1:0] {DISABLED, ARMING, ARMED, FAULT} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          arm_cnt_q, arm_cnt_d;
  logic [MINOR_CNT_W-1:0] minor_cnt_q, minor_cnt_d;
  logic [NUM_SRC:0]       err_src_q, err_src_d;
  logic                   check_en_q, check_en_d;
  logic                   alert_major_q, alert_major_d;
  logic                   alert_minor_q, alert_minor_d;
  logic [NUM_SRC-1:0]     qual_err;
  logic                   qual_minor;
  logic                   thresh_hit;

  // Qualification uses the registered enable so checkers and this block agree.
  assign qual_err   = src_err_i & ~src_mask_i & {NUM_SRC{check_en_q}};
  assign qual_minor = (|(src_minor_i & ~src_mask_i)) & check_en_q;

  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    minor_cnt_d   = minor_cnt_q;
    err_src_d     = err_src_q;
    alert_major_d = alert_major_q;
    alert_minor_d = 1'b0;
    thresh_hit    = 1'b0;
    case (state_q)
      DISABLED: begin
        if (hardening_en_i) begin
          state_d   = (ARM_DELAY == 0) ? ARMED : ARMING;
          arm_cnt_d = ARM_INIT;
        end
      end
      ARMING: begin
        if (!hardening_en_i)      state_d = DISABLED;
        else if (arm_cnt_q == '0) state_d = ARMED;
        else                      arm_cnt_d = arm_cnt_q - 1'b1;
      end
      ARMED: begin
        if (qual_minor) begin
          alert_minor_d = 1'b1;
          if (minor_cnt_q != CNT_MAX) minor_cnt_d = minor_cnt_q + 1'b1;
          thresh_hit = (minor_cnt_d >= THRESH);
        end
        if ((|qual_err) || thresh_hit) begin
          state_d       = FAULT;
          alert_major_d = 1'b1;
          err_src_d     = {thresh_hit, qual_err};
        end else if (!hardening_en_i) begin
          state_d     = DISABLED;
          minor_cnt_d = '0;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    check_en_d = (state_d == ARMED) && !debug_mode_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= DISABLED;
      arm_cnt_q     <= '0;
      minor_cnt_q   <= '0;
      err_src_q     <= '0;
      check_en_q    <= 1'b0;
      alert_major_q <= 1'b0;
      alert_minor_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      minor_cnt_q   <= minor_cnt_d;
      err_src_q     <= err_src_d;
      check_en_q    <= check_en_d;
      alert_major_q <= alert_major_d;
      alert_minor_q <= alert_minor_d;
    end
  end

  assign check_en_o    = check_en_q;
  assign alert_major_o = alert_major_q;
  assign alert_minor_o = alert_minor_q;
  assign err_src_o     = err_src_q;
  assign minor_cnt_o   = minor_cnt_q;

endmodule

// File: tb/tb_cv32e40s_hardening_alert_ctrl.sv
// Directed bench for cv32e40s_hardening_alert_ctrl with default parameters.
module tb_cv32e40s_hardening_alert_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hardening_en_i = 1'b0;
  logic       debug_mode_i = 1'b0;
  logic [3:0] src_err_i = '0;
  logic [3:0] src_minor_i = '0;
  logic [3:0] src_mask_i = '0;
  logic       check_en_o;
  logic       alert_major_o;
  logic       alert_minor_o;
  logic [4:0] err_src_o;
  logic [3:0] minor_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  cv32e40s_hardening_alert_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hardening_en_i(hardening_en_i),
    .debug_mode_i(debug_mode_i), .src_err_i(src_err_i), .src_minor_i(src_minor_i),
    .src_mask_i(src_mask_i), .check_en_o(check_en_o), .alert_major_o(alert_major_o),
    .alert_minor_o(alert_minor_o), .err_src_o(err_src_o), .minor_cnt_o(minor_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".check_en"}, 32'(check_en_o), 0);
    chk({tag, ".major"},    32'(alert_major_o), 0);
    chk({tag, ".minor"},    32'(alert_minor_o), 0);
    chk({tag, ".err_src"},  32'(err_src_o), 0);
    chk({tag, ".cnt"},      32'(minor_cnt_o), 0);
  endtask

  task automatic do_reset();
    hardening_en_i = 0; debug_mode_i = 0;
    src_err_i = '0; src_minor_i = '0; src_mask_i = '0;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic arm();
    hardening_en_i = 1;
    tick(); tick(); tick();
  endtask

  initial begin
    // 1: reset values and arming window
    #2;
    chk_zero("rst");
    tick();
    rst_n = 1;
    hardening_en_i = 1;
    tick(); chk("arm.c1", 32'(check_en_o), 0);
    tick(); chk("arm.c2", 32'(check_en_o), 0);
    tick(); chk("arm.c3", 32'(check_en_o), 1);

    // 2: simultaneous major errors captured, later errors ignored
    src_err_i = 4'b0101;
    tick();
    chk("maj.alert", 32'(alert_major_o), 1);
    chk("maj.src",   32'(err_src_o), 32'h05);
    chk("maj.cen",   32'(check_en_o), 0);
    src_err_i = 4'b0010;
    tick();
    chk("maj.frozen", 32'(err_src_o), 32'h05);
    // asynchronous reset while in FAULT
    rst_n = 0;
    #1;
    chk_zero("async_rst");

    // 3: minor escalation
    do_reset(); arm();
    for (int i = 0; i < 8; i++) begin
      src_minor_i = 4'b0001;
      tick();
      chk("min.pulse", 32'(alert_minor_o), 1);
      chk("min.cnt",   32'(minor_cnt_o), 32'(i + 1));
      src_minor_i = '0;
      tick();
      chk("min.low", 32'(alert_minor_o), 0);
    end
    chk("min.major", 32'(alert_major_o), 1);
    chk("min.src",   32'(err_src_o), 32'h10);
    chk("min.hold",  32'(minor_cnt_o), 8);

    // 4: masking
    do_reset(); arm();
    src_mask_i = 4'b0001; src_err_i = 4'b0001;
    tick(); tick();
    chk("mask.major", 32'(alert_major_o), 0);
    chk("mask.cen",   32'(check_en_o), 1);
    src_mask_i = 4'b0000;
    tick();
    chk("unmask.major", 32'(alert_major_o), 1);
    chk("unmask.src",   32'(err_src_o), 32'h01);

    // 5: debug pauses checking without re-arming
    do_reset(); arm();
    debug_mode_i = 1;
    tick();
    chk("dbg.cen", 32'(check_en_o), 0);
    src_err_i = 4'b0001;
    tick(); tick();
    chk("dbg.major", 32'(alert_major_o), 0);
    chk("dbg.cen2",  32'(check_en_o), 0);
    debug_mode_i = 0;
    tick();
    chk("undbg.cen",   32'(check_en_o), 1);
    chk("undbg.major", 32'(alert_major_o), 0);
    tick();
    chk("undbg.fault", 32'(alert_major_o), 1);

    // 6: enable drop in ARMING, enable drop + error in ARMED
    do_reset();
    hardening_en_i = 1;
    tick();
    hardening_en_i = 0;
    tick(); chk("drop.c1", 32'(check_en_o), 0);
    tick(); chk("drop.c2", 32'(check_en_o), 0);
    arm();
    chk("rearm.cen", 32'(check_en_o), 1);
    hardening_en_i = 0; src_err_i = 4'b1000;
    tick();
    chk("drop_err.major", 32'(alert_major_o), 1);
    chk("drop_err.src",   32'(err_src_o), 32'h08);
    rst_n = 0;
    #1;
    chk_zero("fault_rst");

    // threshold hit together with major error sets both cause bits
    do_reset(); arm();
    for (int i = 0; i < 7; i++) begin
      src_minor_i = 4'b0100;
      tick();
    end
    chk("thr.cnt7", 32'(minor_cnt_o), 7);
    chk("thr.nofault", 32'(alert_major_o), 0);
    src_err_i = 4'b0010;
    tick();
    src_minor_i = '0; src_err_i = '0;
    chk("thr.src",   32'(err_src_o), 32'h12);
    chk("thr.minor", 32'(alert_minor_o), 1);
    chk("thr.cnt8",  32'(minor_cnt_o), 8);
    tick();
    chk("thr.minor_off", 32'(alert_minor_o), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
